// File: rtl/sha1_msg_verifier.sv
// rtl/sha1_msg_verifier.sv - streaming SHA-1 padder and block sequencer for sha1_core
// Define SHA1_VERIFY_EN to build the expected-digest latch and comparator driving match.
module sha1_msg_verifier #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [$clog2(WORD_W/8):0] in_bytes,
  input  logic [159:0]              expected,
  output logic                      core_init,
  output logic                      core_next,
  output logic [511:0]              core_block,
  input  logic                      core_ready,
  input  logic [159:0]              core_digest,
  input  logic                      core_digest_valid,
  output logic [159:0]              digest,
  output logic                      done,
  output logic                      match,
  output logic                      err
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT0, S_WAIT, S_PAD, S_DONE} state_t;

  state_t           state;
  logic [511:0]     blk;
  logic [6:0]       off;
  logic [LEN_W-1:0] cnt;
  logic             first, blk_final, pad_pending, pad_mark;

  logic             accept;
  logic [6:0]       new_off;
  logic [LEN_W:0]   cnt_sum;
  logic [63:0]      bit_len, bit_len_q;
  logic [WORD_W-1:0] data_m;
  logic [511:0]     placed, marker, fill_blk, blk_last;
  logic             tail_fits;

  assign accept  = in_valid & in_ready;
  assign new_off = off + 7'(in_bytes);
  assign cnt_sum = {1'b0, cnt} + (LEN_W+1)'(in_bytes);
  assign bit_len   = 64'(cnt_sum[LEN_W-1:0]) << 3;
  assign bit_len_q = 64'(cnt) << 3;

  // Bytes beyond in_bytes are masked so stale source data never reaches the block.
  assign data_m   = in_data & ~({WORD_W{1'b1}} >> {in_bytes, 3'b000});
  assign placed   = {data_m, {(512-WORD_W){1'b0}}} >> {off, 3'b000};
  assign marker   = {8'h80, 504'd0} >> {new_off, 3'b000};
  assign fill_blk = blk | placed | (in_last ? marker : 512'd0);
  assign tail_fits = (new_off <= 7'd55);
  assign blk_last  = tail_fits ? {fill_blk[511:64], bit_len} : fill_blk;

  assign core_block = blk;

`ifdef SHA1_VERIFY_EN
  logic [159:0] exp_q;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      blk <= '0;
      off <= '0;
      cnt <= '0;
      first <= 1'b0;
      blk_final <= 1'b0;
      pad_pending <= 1'b0;
      pad_mark <= 1'b0;
      in_ready <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      digest <= '0;
      done <= 1'b0;
      match <= 1'b0;
      err <= 1'b0;
`ifdef SHA1_VERIFY_EN
      exp_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          off <= '0;
          cnt <= '0;
          blk <= '0;
          first <= 1'b1;
          blk_final <= 1'b0;
          pad_pending <= 1'b0;
          pad_mark <= 1'b0;
          err <= 1'b0;
          in_ready <= 1'b1;
`ifdef SHA1_VERIFY_EN
          exp_q <= expected;
`endif
          state <= S_FILL;
        end
        S_FILL: if (accept) begin
          cnt <= cnt_sum[LEN_W-1:0];
          if (cnt_sum[LEN_W]) err <= 1'b1;
          off <= new_off;
          if (in_last) begin
            // A tail that exactly fills the block leaves the 0x80 for the pad block.
            blk <= blk_last;
            blk_final <= tail_fits;
            pad_pending <= !tail_fits;
            pad_mark <= (new_off == 7'd64);
            in_ready <= 1'b0;
            state <= S_ISSUE;
          end else begin
            blk <= fill_blk;
            if (new_off == 7'd64) begin
              blk_final <= 1'b0;
              in_ready <= 1'b0;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          core_init <= first;
          core_next <= !first;
          first <= 1'b0;
          state <= S_WAIT0;
        end
        S_WAIT0: state <= S_WAIT;
        S_WAIT: if (core_ready && (core_digest_valid || !blk_final)) begin
          if (blk_final) begin
            digest <= core_digest;
            done <= 1'b1;
`ifdef SHA1_VERIFY_EN
            match <= (core_digest == exp_q);
`endif
            state <= S_DONE;
          end else if (pad_pending) begin
            state <= S_PAD;
          end else begin
            blk <= '0;
            off <= '0;
            in_ready <= 1'b1;
            state <= S_FILL;
          end
        end
        S_PAD: begin
          blk <= {(pad_mark ? 8'h80 : 8'h00), 440'd0, bit_len_q};
          pad_pending <= 1'b0;
          blk_final <= 1'b1;
          state <= S_ISSUE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_verifier.sv
// tb/tb_sha1_msg_verifier.sv - scoreboard bench for sha1_msg_verifier with a behavioural SHA-1 core
module tb_sha1_msg_verifier;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 8;
  localparam int NB     = WORD_W / 8;
  localparam int IB     = $clog2(NB) + 1;
  localparam logic [159:0] IV       = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] DIG_EMPTY= 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] DIG_55   = 160'h58141f4f10dda66ff7efdf84217399e5ab6b963b;
  localparam logic [159:0] DIG_56   = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  typedef logic [7:0] u8_q [$];
  typedef struct { logic [159:0] dig; logic m; } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic [IB-1:0] in_bytes = '0;
  logic [159:0] expected = '0;
  logic in_ready, core_init, core_next, done, match, err;
  logic [511:0] core_block;
  logic core_ready, core_dv;
  logic [159:0] h_st, digest;

  int n_checks = 0, n_fail = 0;
  int n_init = 0, n_next = 0, busy = 0;
  logic [511:0] last_blk = '0;
  sb_t sb[$];

  always #5 clk = ~clk;

  sha1_msg_verifier #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .expected(expected),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(h_st), .core_digest_valid(core_dv),
    .digest(digest), .done(done), .match(match), .err(err)
  );

  function automatic logic [159:0] compress(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:79];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    {a, b, c, d, e} = hin;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  function automatic logic [159:0] sha1_ref(input u8_q m, input logic [63:0] bitlen);
    u8_q p;
    logic [159:0] h;
    logic [511:0] b;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    h = IV;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      h = compress(h, b);
    end
    return h;
  endfunction

  function automatic u8_q str2q(input string s);
    u8_q q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic exp_match(input logic [159:0] dig, input logic [159:0] ref_in);
`ifdef SHA1_VERIFY_EN
    return dig == ref_in;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural core: ready drops the edge after a pulse, returns after a random latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready <= 1'b1; core_dv <= 1'b0; busy <= 0; h_st <= '0;
    end else if (core_init || core_next) begin
      h_st <= compress(core_init ? IV : h_st, core_block);
      core_ready <= 1'b0; core_dv <= 1'b0;
      busy <= $urandom_range(2, 6);
      n_init <= n_init + (core_init ? 1 : 0);
      n_next <= n_next + (core_next ? 1 : 0);
      last_blk <= core_block;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy <= 0; core_ready <= 1'b1; core_dv <= 1'b1;
    end
  end

  task automatic start_msg(input logic [159:0] exp_in, input logic [159:0] exp_dig);
    @(negedge clk); expected = exp_in; start = 1'b1;
    @(negedge clk); start = 1'b0;
    sb.push_back('{exp_dig, exp_match(exp_dig, exp_in)});
  endtask

  task automatic send_msg(input u8_q m, input bit toggle);
    int total, words, w, budget;
    logic [WORD_W-1:0] d;
    bit ph;
    total = m.size();
    words = (total == 0) ? 1 : (total + NB - 1) / NB;
    w = 0; budget = 0; ph = 1'b0;
    while (w < words && budget < 3000) begin
      @(negedge clk); budget++;
      for (int j = 0; j < NB; j++)
        d[WORD_W-1-8*j -: 8] = (w*NB + j < total) ? m[w*NB + j] : 8'($urandom);
      in_data = d;
      in_last = (w == words - 1);
      in_bytes = IB'(in_last ? total - w*NB : NB);
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (in_valid && in_ready) w++;
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (w != words) begin n_fail++; $display("FAIL send_timeout: words accepted %0d required %0d", w, words); end
  endtask

  task automatic wait_done(output bit seen, output logic [159:0] d, output logic m, output bit rdy_seen);
    seen = 1'b0; rdy_seen = 1'b0; d = '0; m = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (in_ready) rdy_seen = 1'b1;
      if (done) begin seen = 1'b1; d = digest; m = match; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (core_init !== 1'b0)  begin n_fail++; $display("FAIL rst_core_init: got %b want 0", core_init); end
    if (core_next !== 1'b0)  begin n_fail++; $display("FAIL rst_core_next: got %b want 0", core_next); end
    if (core_block !== '0)   begin n_fail++; $display("FAIL rst_core_block: got %h want 0", core_block); end
    if (digest !== '0)       begin n_fail++; $display("FAIL rst_digest: got %h want 0", digest); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    if (match !== 1'b0)      begin n_fail++; $display("FAIL rst_match: got %b want 0", match); end
    if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_abc();
    sb_t e; logic [159:0] d; logic m; bit seen, rs; int i0, x0;
    i0 = n_init; x0 = n_next;
    start_msg(DIG_ABC, DIG_ABC);
    send_msg(str2q("abc"), 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 5;
    if (!seen)              begin n_fail++; $display("FAIL abc_done: got timeout want done"); end
    if (d !== e.dig)        begin n_fail++; $display("FAIL abc_digest: got %h want %h", d, e.dig); end
    if (m !== e.m)          begin n_fail++; $display("FAIL abc_match: got %b want %b", m, e.m); end
    if (n_init - i0 != 1)   begin n_fail++; $display("FAIL abc_inits: got %0d want 1", n_init - i0); end
    if (n_next - x0 != 0)   begin n_fail++; $display("FAIL abc_nexts: got %0d want 0", n_next - x0); end
  endtask

  task automatic test_empty();
    sb_t e; logic [159:0] d; logic m; bit seen, rs; u8_q q;
    start_msg(DIG_EMPTY, DIG_EMPTY);
    send_msg(q, 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 2;
    if (d !== e.dig) begin n_fail++; $display("FAIL empty_digest: got %h want %h", d, e.dig); end
    if (m !== e.m)   begin n_fail++; $display("FAIL empty_match: got %b want %b", m, e.m); end
  endtask

  task automatic test_single_55();
    sb_t e; logic [159:0] d; logic m; bit seen, rs; int x0;
    x0 = n_next;
    start_msg(DIG_55, DIG_55);
    send_msg(str2q("thequickbrownfoxjumpsoverthelazydogthequickbrownfoxjump"), 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 3;
    if (d !== e.dig)                 begin n_fail++; $display("FAIL b55_digest: got %h want %h", d, e.dig); end
    if (last_blk[63:0] !== 64'h1b8)  begin n_fail++; $display("FAIL b55_lenfield: got %h want 1b8", last_blk[63:0]); end
    if (n_next - x0 != 0)            begin n_fail++; $display("FAIL b55_nexts: got %0d want 0", n_next - x0); end
  endtask

  task automatic test_pad_56();
    sb_t e; logic [159:0] d; logic m; bit seen, rs; int i0, x0;
    i0 = n_init; x0 = n_next;
    start_msg(~DIG_56, DIG_56);
    send_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 4;
    if (d !== e.dig)      begin n_fail++; $display("FAIL p56_digest: got %h want %h", d, e.dig); end
    if (m !== 1'b0)       begin n_fail++; $display("FAIL p56_match: got %b want 0", m); end
    if (n_init - i0 != 1) begin n_fail++; $display("FAIL p56_inits: got %0d want 1", n_init - i0); end
    if (n_next - x0 != 1) begin n_fail++; $display("FAIL p56_nexts: got %0d want 1", n_next - x0); end
  endtask

  task automatic test_full_64_toggle();
    sb_t e; logic [159:0] d, r; logic m; bit seen, rs; int x0; u8_q q;
    for (int i = 0; i < 64; i++) q.push_back(8'(i*7 + 3));
    r = sha1_ref(q, 64'd512);
    x0 = n_next;
    start_msg(r, r);
    send_msg(q, 1'b1);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 5;
    if (d !== e.dig)                begin n_fail++; $display("FAIL f64_digest: got %h want %h", d, e.dig); end
    if (m !== e.m)                  begin n_fail++; $display("FAIL f64_match: got %b want %b", m, e.m); end
    if (last_blk[511:504] !== 8'h80) begin n_fail++; $display("FAIL f64_pad_byte0: got %h want 80", last_blk[511:504]); end
    if (n_next - x0 != 1)           begin n_fail++; $display("FAIL f64_nexts: got %0d want 1", n_next - x0); end
    if (rs)                         begin n_fail++; $display("FAIL f64_in_ready_low: got 1 want 0"); end
  endtask

  task automatic test_len_overflow();
    sb_t e; logic [159:0] d, r; logic m; bit seen, rs; u8_q q;
    for (int i = 0; i < 260; i++) q.push_back(8'(i));
    r = sha1_ref(q, 64'd32);
    start_msg(r, r);
    send_msg(q, 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 2;
    if (d !== e.dig)  begin n_fail++; $display("FAIL ovf_digest: got %h want %h", d, e.dig); end
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err); end
    start_msg(DIG_ABC, DIG_ABC);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %b want 0", err); end
    send_msg(str2q("abc"), 1'b0);
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks++;
    if (d !== e.dig)  begin n_fail++; $display("FAIL ovf_next_digest: got %h want %h", d, e.dig); end
  endtask

  task automatic test_reset_mid();
    bit found; sb_t e;
    start_msg(DIG_56, DIG_56);
    send_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (!core_ready) found = 1'b1; else @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_wait_busy: got ready stuck want busy"); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks += 7;
    if (core_init !== 1'b0) begin n_fail++; $display("FAIL mid_core_init: got %b want 0", core_init); end
    if (core_next !== 1'b0) begin n_fail++; $display("FAIL mid_core_next: got %b want 0", core_next); end
    if (core_block !== '0)  begin n_fail++; $display("FAIL mid_core_block: got %h want 0", core_block); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    if (digest !== '0)      begin n_fail++; $display("FAIL mid_digest: got %h want 0", digest); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
    if (match !== 1'b0)     begin n_fail++; $display("FAIL mid_match: got %b want 0", match); end
    e = sb.pop_front();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sb_t e; logic [159:0] d; logic m; bit seen, rs, extra;
    start_msg(DIG_ABC, DIG_ABC);
    send_msg(str2q("abc"), 1'b0);
    expected = ~DIG_ABC; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(seen, d, m, rs);
    e = sb.pop_front();
    n_checks += 3;
    if (!seen)       begin n_fail++; $display("FAIL b2b_done: got timeout want done"); end
    if (d !== e.dig) begin n_fail++; $display("FAIL b2b_digest: got %h want %h", d, e.dig); end
    if (m !== e.m)   begin n_fail++; $display("FAIL b2b_match: got %b want %b", m, e.m); end
    extra = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || in_ready) extra = 1'b1;
    end
    n_checks++;
    if (extra) begin n_fail++; $display("FAIL b2b_busy_start: got activity want idle"); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_single_55();
    test_pad_56();
    test_full_64_toggle();
    test_len_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha1_msg_verifier.md
# sha1_msg_verifier

Streaming SHA-1 front end that sits between a byte-oriented message source and the existing `sha1_core`. It accepts an arbitrary-length message as a stream of `WORD_W`-bit words and packs it into 512-bit blocks. It applies FIPS 180-4 padding, sequences the core through `init`/`next` for every block, and captures the final digest. Optionally, it compares that digest against an expected value to produce the verification bit used by the AES/SHA integrity path.

## Interface

**Parameters**

- `WORD_W`, default 32: input word width in bits. Must be 8, 16, 32 or 64.
- `LEN_W`, default 32: width of the internal message byte counter. Range 8..61.

**Ports**

- `clk` in 1: system clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that opens a new message. Honoured only in IDLE.
- `in_valid` in 1: source word valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in WORD_W: message bytes, first byte in the MSBs.
- `in_last` in 1: the word is the final word of the message.
- `in_bytes` in $clog2(WORD_W/8)+1: number of valid bytes, counted from the MSB.
  - Equals WORD_W/8 unless `in_last` is high.
  - 0 is legal only with `in_last` (empty tail).
- `expected` in 160: reference digest. Sampled on `start`.
- `core_init` out 1: one-cycle pulse for the first block.
- `core_next` out 1: one-cycle pulse for each later block.
- `core_block` out 512: block presented to the core. Held stable from the pulse until `core_ready` returns.
- `core_ready` in 1: core idle.
- `core_digest` in 160: core digest.
- `core_digest_valid` in 1: core digest valid.
- `digest` out 160: final digest. Held until the next `start`.
- `done` out 1: one-cycle pulse when `digest` is updated.
- `match` out 1: `digest == expected`. Valid while `done` is high and held afterwards.
- `err` out 1: the byte counter overflowed. Sticky until `start`.

## Operation

**States:** IDLE, FILL, ISSUE, WAIT0, WAIT, PAD, DONE.

**IDLE**
- On `start`: clear the byte count, clear the block buffer, clear `first` to 1, latch `expected`, go to FILL.

**FILL**
- `in_ready` = 1 while fewer than 64 bytes are buffered.
- Each accepted word appends `in_bytes` bytes big-endian at the current byte offset. `WORD_W` divides 512, so full words never straddle blocks.
- When the buffer reaches 64 bytes, go to ISSUE with `blk_final` = 0.
- On an accepted `in_last`:
  - Append 0x80 after the last valid byte.
  - If the resulting offset is ≤ 56: zero-fill, write the 64-bit big-endian bit length (byte count × 8, zero-extended from `LEN_W`+3 bits) into bytes 56..63, and go to ISSUE with `blk_final` = 1.
  - Otherwise: zero-fill, go to ISSUE with `blk_final` = 0, and set `pad_pending`.

**ISSUE**
- Drive `core_block` from the buffer.
- Pulse `core_init` if `first`, else pulse `core_next`. Clear `first`.
- Go to WAIT0.

**WAIT0**
- One cycle with `core_ready` ignored, because the core drops `ready` one cycle after the pulse. Go to WAIT.

**WAIT**
- Hold until `core_ready` = 1, then:
  - If `blk_final`: go to DONE.
  - Else if `pad_pending`: go to PAD.
  - Else: clear the buffer and go to FILL.

**PAD**
- Build the block as all zeros plus the length field, set `blk_final` = 1, go to ISSUE.
- A message of exactly 64k bytes gets its 0x80 at byte 0 of this pad block.

**DONE**
- Register `core_digest` into `digest`, pulse `done`, set `match`, go to IDLE.

**Other rules**
- The byte counter adds `in_bytes` per accepted word.
- On a carry out of `LEN_W`: set `err`. The count wraps and processing continues.
- `start` outside IDLE is ignored.
- `in_valid` outside FILL is ignored, because `in_ready` = 0.

## Timing

- Reset values: every output is 0, `state` = IDLE, buffer cleared.
- Reset mid-message aborts immediately. `core_init`/`core_next` are low from the reset edge. The core itself must be reset by the same signal.
- Input acceptance: one word per cycle when `in_valid & in_ready`.
- Per-block overhead beyond the core's own latency: 3 cycles (ISSUE, WAIT0, and the exit cycle from WAIT).
- `done` rises 1 cycle after the final `core_ready` is observed.
- `in_ready` and `start` never cause combinational paths to outputs.

## Configuration

- `SHA1_VERIFY_EN` defined: the `expected` latch and the 160-bit comparator are built, and `match` operates as described.
- `SHA1_VERIFY_EN` undefined:
  - `expected` is unused.
  - `match` is tied to 0.
  - The latch and comparator are removed.
  - `digest` and `done` are unchanged.

## Test plan

- "abc" (3 bytes, WORD_W=32, `in_bytes`=3 with `in_last`) → one `core_init`, no `core_next`, digest a9993e364706816aba3e25717850c26c9cd0d89d, `match` = 1 with the matching `expected`.
- Empty message (single word with `in_bytes`=0 and `in_last`) → digest da39a3ee5e6b4b0d3255bfef95601890afd80709.
- 55-byte "thequickbrownfoxjumpsoverthelazydogthequickbrownfoxjump" → single block ending in length field 0x1B8, digest 58141f4f10dda66ff7efdf84217399e5ab6b963b.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → exactly one `core_init` and one `core_next` (PAD path), digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1. A wrong `expected` gives `match` = 0.
- 64-byte message with `in_valid` toggling every other cycle → two blocks, second block begins 0x80. `in_ready` is low from the 16th word until the first WAIT exits.
- Assert `reset` during WAIT of a two-block message → all outputs 0 next cycle. A following "abc" run passes. A `start` pulsed while busy produces no effect.
